// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read engine: 1-cycle-latency pops into a 2-entry skid buffer feeding a valid/ready stream
module fifo_stream_reader #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fifo_empty,
   output logic              fifo_rd_en,
   input  logic [DATA_W-1:0] fifo_dout,
   input  logic              flush,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic [1:0]        occupancy,
   output logic [15:0]       rd_count
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   logic [1:0]        r_occ;
   logic [DATA_W-1:0] r_head;
   logic [DATA_W-1:0] r_tail;
   logic              r_inflight;
   logic              r_discard;
   logic [15:0]       r_rd_count;

   logic              w_pop;
   logic              w_push;
   logic [2:0]        w_credit;

   assign w_pop    = m_valid & m_ready;
   assign w_push   = r_inflight & ~r_discard & ~reset;
   assign w_credit = {1'b0, r_occ} + {2'b00, r_inflight};

   // A slot freed by this cycle's pop may be re-requested now, keeping one word per cycle.
   assign fifo_rd_en = ~reset & ~flush & ~fifo_empty & (w_credit < (3'd2 + {2'b00, w_pop}));

   assign m_valid   = (r_occ != ST_EMPTY);
   assign m_data    = r_head;
   assign occupancy = r_occ;
   assign rd_count  = r_rd_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_occ      <= ST_EMPTY;
         r_head     <= '0;
         r_tail     <= '0;
         r_inflight <= 1'b0;
         r_discard  <= 1'b0;
         r_rd_count <= 16'd0;
      end else begin
         r_inflight <= fifo_rd_en;
         if (w_pop)
            r_rd_count <= r_rd_count + 16'd1;
         if (flush) begin
            r_occ     <= ST_EMPTY;
            r_discard <= r_inflight;
         end else begin
            r_discard <= 1'b0;
            case (r_occ)
               ST_EMPTY: begin
                  if (w_push) begin
                     r_head <= fifo_dout;
                     r_occ  <= ST_ONE;
                  end
               end
               ST_ONE: begin
                  if (w_push && !w_pop) begin
                     r_tail <= fifo_dout;
                     r_occ  <= ST_TWO;
                  end else if (!w_push && w_pop) begin
                     r_occ  <= ST_EMPTY;
                  end else if (w_push && w_pop) begin
                     r_head <= fifo_dout;
                  end
               end
               ST_TWO: begin
                  if (w_pop) begin
                     r_head <= r_tail;
                     if (w_push)
                        r_tail <= fifo_dout;
                     else
                        r_occ <= ST_ONE;
                  end
               end
               default: r_occ <= ST_EMPTY;
            endcase
         end
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(r_occ == ST_TWO && w_push && !w_pop));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed bench for fifo_stream_reader with a 1-cycle-latency FIFO model
module tb_fifo_stream_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [31:0] fifo_dout;
   logic        flush;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic [1:0]  occupancy;
   logic [15:0] rd_count;

   fifo_stream_reader #(.DATA_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_dout  (fifo_dout),
      .flush      (flush),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .occupancy  (occupancy),
      .rd_count   (rd_count)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:255];
   logic [31:0] rp = 32'd0;
   logic [31:0] wp = 32'd0;

   assign fifo_empty = (rp == wp);

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_dout <= mem[rp[7:0]];
         rp        <= rp + 32'd1;
      end
   end

   int n_checks = 0;
   int n_err    = 0;
   int n_rden   = 0;
   int n_pop    = 0;
   bit chk_wrap = 1'b0;
   logic [31:0] got [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [31:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         mem[wp[7:0]] = first + i;
         wp = wp + 32'd1;
      end
   endtask

   task automatic smp;
      @(negedge clk);
      if (m_valid && m_ready) begin
         if (chk_wrap && n_pop == 65535)
            check("wrap_ffff", {16'd0, rd_count}, 32'h0000_FFFF);
         n_pop++;
         if (got.size() < 64)
            got.push_back(m_data);
      end
      if (fifo_rd_en)
         n_rden++;
   endtask

   task automatic adv;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset   = 1'b1;
      flush   = 1'b0;
      m_ready = 1'b0;
      load(32'h11, 8);

      // reset held two cycles with a non-empty FIFO
      adv; adv;
      smp;
      check("rst_rden", {31'd0, fifo_rd_en}, 32'd0);
      check("rst_valid", {31'd0, m_valid}, 32'd0);
      check("rst_occ", {30'd0, occupancy}, 32'd0);
      check("rst_cnt", {16'd0, rd_count}, 32'd0);
      check("rst_data", m_data, 32'd0);
      adv;

      // full-throughput streaming
      reset   = 1'b0;
      m_ready = 1'b1;
      got.delete();
      for (int i = 0; i < 10; i++) begin
         smp;
         if (i == 0)
            check("t2_rden0", {31'd0, fifo_rd_en}, 32'd1);
         if (i < 2) begin
            check("t2_novalid", {31'd0, m_valid}, 32'd0);
         end else begin
            check("t2_valid", {31'd0, m_valid}, 32'd1);
            check("t2_data", m_data, 32'h11 + i - 2);
         end
         adv;
      end
      smp;
      check("t2_cnt", {16'd0, rd_count}, 32'd8);
      check("t2_idle", {31'd0, m_valid}, 32'd0);
      adv;

      // backpressure: only two reads issued, head stable
      m_ready = 1'b0;
      load(32'h11, 8);
      n_rden = 0;
      for (int i = 0; i < 6; i++) begin
         smp;
         if (m_valid)
            check("t3_stable", m_data, 32'h11);
         adv;
      end
      smp;
      check("t3_rden", n_rden, 32'd2);
      check("t3_occ", {30'd0, occupancy}, 32'd2);
      check("t3_data", m_data, 32'h11);
      adv;
      m_ready = 1'b1;
      got.delete();
      repeat (14) begin smp; adv; end
      check("t3_n", got.size(), 32'd8);
      for (int i = 0; i < 8 && i < got.size(); i++)
         check("t3_order", got[i], 32'h11 + i);
      check("t3_cnt", {16'd0, rd_count}, 32'd16);

      // FIFO runs dry then refills
      got.delete();
      n_rden = 0;
      load(32'h11, 3);
      repeat (8) begin smp; adv; end
      check("t4_rden", n_rden, 32'd3);
      check("t4_n", got.size(), 32'd3);
      for (int i = 0; i < 3 && i < got.size(); i++)
         check("t4_order", got[i], 32'h11 + i);
      check("t4_fall", {31'd0, m_valid}, 32'd0);
      load(32'h14, 1);
      repeat (5) begin smp; adv; end
      check("t4_refill_n", got.size(), 32'd4);
      if (got.size() == 4)
         check("t4_refill", got[3], 32'h14);

      // flush with a word in flight
      got.delete();
      load(32'h21, 8);
      smp; adv;
      smp; adv;
      smp; adv;
      m_ready = 1'b0;
      flush   = 1'b1;
      smp;
      check("t5_rden_fl", {31'd0, fifo_rd_en}, 32'd0);
      adv;
      flush   = 1'b0;
      m_ready = 1'b1;
      smp;
      check("t5_occ", {30'd0, occupancy}, 32'd0);
      check("t5_valid", {31'd0, m_valid}, 32'd0);
      check("t5_hold", m_data, 32'h22);
      check("t5_cnt", {16'd0, rd_count}, 32'd21);
      check("t5_rden", {31'd0, fifo_rd_en}, 32'd1);
      adv;
      repeat (10) begin smp; adv; end
      check("t5_n", got.size(), 32'd6);
      if (got.size() == 6) begin
         check("t5_first", got[0], 32'h21);
         for (int i = 1; i < 6; i++)
            check("t5_order", got[i], 32'h23 + i);
      end
      check("t5_cnt_end", {16'd0, rd_count}, 32'd26);

      // reset with a read in flight
      got.delete();
      load(32'h31, 6);
      smp; adv;
      reset = 1'b1;
      smp;
      check("t6_rden_rst", {31'd0, fifo_rd_en}, 32'd0);
      adv;
      reset = 1'b0;
      smp;
      check("t6_occ", {30'd0, occupancy}, 32'd0);
      check("t6_valid", {31'd0, m_valid}, 32'd0);
      check("t6_data", m_data, 32'd0);
      check("t6_cnt", {16'd0, rd_count}, 32'd0);
      adv;
      smp;
      check("t6_nospur", {31'd0, m_valid}, 32'd0);
      adv;
      repeat (10) begin smp; adv; end
      check("t6_n", got.size(), 32'd5);
      for (int i = 0; i < 5 && i < got.size(); i++)
         check("t6_order", got[i], 32'h32 + i);
      check("t6_cnt_end", {16'd0, rd_count}, 32'd5);

      // rd_count wrap after 65536 deliveries
      reset = 1'b1;
      adv;
      reset    = 1'b0;
      got.delete();
      n_pop    = 0;
      chk_wrap = 1'b1;
      wp       = wp + 32'd65536;
      repeat (65545) begin smp; adv; end
      chk_wrap = 1'b0;
      check("t7_pops", n_pop, 32'd65536);
      check("t7_wrap", {16'd0, rd_count}, 32'd0);
      check("t7_idle", {31'd0, m_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
